// File: rtl/display_pkg.sv
// Shared types and segment constants for the 4-digit multiplexed 7-segment display.
package display_pkg;
    typedef logic [3:0] bcd_t;
    typedef logic [1:0] slot_t;

    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [3:0] ANODE_OFF = 4'b1111;

    // Active-high {g,f,e,d,c,b,a}; codes 10..15 light only g (dash).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment pattern; codes above 9 show a dash.
module bcd_to_7seg
    import display_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] seg
);
    assign seg = (digit > 4'd9) ? SEG_DASH : ~SEG_TABLE[digit];
endmodule

// File: rtl/display_7seg_mux.sv
// Latches four BCD digits on ready and time-multiplexes them onto a common-anode display.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros (units digit always shown).
module display_7seg_mux
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  bcd_t       unidades_input,
    input  bcd_t       decenas_input,
    input  bcd_t       centenas_input,
    input  bcd_t       millares_input,
    input  logic       ready,
    output logic [3:0] anodo_output,
    output logic [6:0] segmentos_output
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0]   presc, presc_nxt;
    bcd_t [3:0]      digits, digits_nxt;
    slot_t           slot, slot_nxt;
    logic            tick;
    logic            blank;
    logic [6:0]      seg_sel;

    assign tick = (presc == PW'(REFRESH_DIV - 1));

    always_comb begin
        digits_nxt = ready ? {millares_input, centenas_input, decenas_input, unidades_input}
                           : digits;
        presc_nxt  = tick ? '0 : presc + PW'(1);
        slot_nxt   = slot + slot_t'(tick);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] lz;
    // lz[k]: digit k and every higher digit are zero.
    always_comb begin
        lz[3] = (digits_nxt[3] == 4'd0);
        lz[2] = lz[3] && (digits_nxt[2] == 4'd0);
        lz[1] = lz[2] && (digits_nxt[1] == 4'd0);
        lz[0] = 1'b0;
        blank = lz[slot_nxt];
    end
`else
    assign blank = 1'b0;
`endif

    bcd_to_7seg u_dec (
        .digit (digits_nxt[slot_nxt]),
        .seg   (seg_sel)
    );

    // Outputs are registered from the next-state view so new data/slot appear one edge later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits           <= '0;
            presc            <= '0;
            slot             <= '0;
            anodo_output     <= ANODE_OFF;
            segmentos_output <= SEG_OFF;
        end else begin
            digits           <= digits_nxt;
            presc            <= presc_nxt;
            slot             <= slot_nxt;
            anodo_output     <= blank ? ANODE_OFF : ~(4'b0001 << slot_nxt);
            segmentos_output <= blank ? SEG_OFF : seg_sel;
        end
    end
endmodule
